// File: rtl/alu_pkg.sv
// Shared types for the ALU decode/issue stage.
// Opcode, funct and ALU select encodings plus the issue bundle.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_XOR   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_AND   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_LUI   = 4'd10,
    ALU_AUIPC = 4'd11
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_e     alu_sel;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } alu_issue_t;

  // alt selects SUB for f3=000 and SRA for f3=101
  function automatic alu_op_e f3_to_op(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_e op;
    op = ALU_ADD;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I ALU-class decoder.
// Produces ALU select, operands and legality for one instruction.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output alu_issue_t  dec
);

  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic        is_sh;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign is_sh = (f3 == F3_SLL) || (f3 == F3_SR);
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_u = {12'b0, instr[31:12]};
  assign shamt = {27'b0, instr[24:20]};

  always_comb begin
    dec         = '0;
    dec.rd      = instr[11:7];
    dec.illegal = 1'b0;
    unique case (1'b1)
      (opc == OPC_OP): begin
        dec.alu_sel = f3_to_op(f3, f7[5]);
        dec.op_a    = rs1;
        dec.op_b    = is_sh ? {27'b0, rs2[4:0]} : rs2;
        dec.illegal = !((f7 == F7_BASE) ||
                        ((f7 == F7_ALT) &&
                         ((f3 == F3_ADD) || (f3 == F3_SR))));
      end
      (opc == OPC_OP_IMM): begin
        // imm bit 30 only means SRA for the right-shift form
        dec.alu_sel = f3_to_op(f3, f7[5] && (f3 == F3_SR));
        dec.op_a    = rs1;
        dec.op_b    = is_sh ? shamt : imm_i;
        dec.illegal = ((f3 == F3_SLL) && (f7 != F7_BASE)) ||
                      ((f3 == F3_SR) && (f7 != F7_BASE) &&
                       (f7 != F7_ALT));
      end
      (opc == OPC_LUI): begin
        dec.alu_sel = ALU_LUI;
        dec.op_b    = imm_u;
      end
      (opc == OPC_AUIPC): begin
        dec.alu_sel = ALU_AUIPC;
        dec.op_a    = pc;
        dec.op_b    = imm_u;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.rd_we = !dec.illegal;
    if (dec.illegal) begin
      dec.alu_sel = ALU_ADD;
      dec.op_a    = '0;
      dec.op_b    = '0;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Registered ALU issue stage: decode into an output register
// backed by a one-entry skid buffer so in_ready is a flop.
module alu_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_alu_sel,
  output logic [31:0] out_op_a,
  output logic [31:0] out_op_b,
  output logic [4:0]  out_rd,
  output logic        out_rd_we,
  output logic        out_illegal
);

  alu_issue_t dec;
  alu_issue_t out_q;
  alu_issue_t skid_q;
  logic       out_v;
  logic       skid_v;
  logic       accept;
  logic       load;

  alu_decode u_dec (
    .instr (in_instr),
    .pc    (in_pc),
    .rs1   (in_rs1_data),
    .rs2   (in_rs2_data),
    .dec   (dec)
  );

  assign in_ready = !skid_v;
  assign accept   = in_valid && !skid_v;
  assign load     = !out_v || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (flush) begin
      out_q  <= '0;
      skid_q <= '0;
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (load) begin
      // skid full implies in_ready low, so no accept here
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= 1'b0;
      end else if (accept) begin
        out_q <= dec;
        out_v <= 1'b1;
      end else begin
        out_v <= 1'b0;
      end
    end else if (accept) begin
      skid_q <= dec;
      skid_v <= 1'b1;
    end
  end

  assign out_valid   = out_v;
  assign out_alu_sel = out_q.alu_sel;
  assign out_op_a    = out_q.op_a;
  assign out_op_b    = out_q.op_b;
  assign out_rd      = out_q.rd;
  assign out_rd_we   = out_q.rd_we;
  assign out_illegal = out_q.illegal;

endmodule

// File: doc/alu_issue.md
# alu_issue

Registered decode/issue stage that drives the ALU. It accepts one RV32I ALU-class instruction per cycle with its PC and register operands over a valid/ready handshake. It decodes the instruction into the ALU's 4-bit operation select plus operands A and B. The results leave through a registered output with a skid buffer, giving full throughput with no combinational ready path.

## Interface
- No parameters; XLEN fixed at 32.
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `flush` in 1 — synchronous; empties the stage.
- `in_valid` in 1 — upstream beat valid.
- `in_ready` out 1 — stage can accept a beat; driven from a register.
- `in_instr` in 32 — instruction word.
- `in_pc` in 32 — PC of the instruction.
- `in_rs1_data` in 32 — rs1 value.
- `in_rs2_data` in 32 — rs2 value.
- `out_valid` out 1 — issued beat valid.
- `out_ready` in 1 — ALU/execute side accepts the beat.
- `out_alu_sel` out 4 — ALU operation code.
- `out_op_a` out 32 — ALU operand A.
- `out_op_b` out 32 — ALU operand B.
- `out_rd` out 5 — destination register, `instr[11:7]`.
- `out_rd_we` out 1 — register write enable.
- `out_illegal` out 1 — the instruction is not a legal ALU-class instruction.

## Operation
- ALU codes: ADD 0, SUB 1, XOR 2, OR 3, AND 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, LUI 10, AUIPC 11.
- The ALU computes `B<<12` for code 10 and `A+(B<<12)` for code 11.
- The ALU shifts by the full 32-bit B. The decoder therefore always zero-extends the 5-bit shift amount into B.
- OP (`0110011`):
  - A = rs1, B = rs2.
  - For shifts, B = {27'b0, rs2[4:0]}.
  - funct7 must be `0000000`, or `0100000` with funct3 000 (SUB) or 101 (SRA).
- OP-IMM (`0010011`):
  - A = rs1, B = sign-extended `instr[31:20]`.
  - SLTIU uses the same sign-extended immediate.
  - SLLI requires funct7 `0000000`; B = zero-extended `instr[24:20]`.
  - SRLI/SRAI require funct7 `0000000` (SRL) or `0100000` (SRA); B = zero-extended `instr[24:20]`.
- LUI (`0110111`): A = 0, B = {12'b0, `instr[31:12]`}, code 10.
- AUIPC (`0010111`): A = pc, B = {12'b0, `instr[31:12]`}, code 11.
- Illegal instruction (any other opcode or funct combination):
  - illegal = 1, rd_we = 0, alu_sel = 0, A = B = 0.
  - The beat is still issued, so the handshake does not stall.
- rd_we = 1 for every legal instruction, including rd = x0. Dropping x0 writes is the register file's job.

## Timing
- Reset values:
  - out_valid = 0, in_ready = 1.
  - All payload outputs = 0.
  - Skid buffer empty.
- Latency: a beat accepted at edge N appears on the outputs after edge N when the output register is free.
- Output register:
  - Loads when it is empty or `out_ready` = 1.
  - Source is the skid entry if the skid is full, otherwise the input.
- Skid buffer:
  - A beat accepted while the output holds a beat and `out_ready` = 0 goes into the skid entry.
  - `in_ready` falls on the next cycle.
  - `in_ready` = !skid_full, registered.
  - The skid drains into the output on the first cycle `out_ready` = 1; `in_ready` rises on the following cycle.
- Throughput: 1 beat/cycle when `out_ready` is held high.
- Payload outputs hold stable while out_valid = 1 and out_ready = 0.
- `flush`:
  - Next state is the reset state.
  - A beat presented in the flush cycle is dropped.
  - flush overrides a simultaneous accept or drain.
- Reset asserted mid-stream clears both entries immediately. The first cycle after deassertion has in_ready = 1.

## Structure
- Package `alu_pkg`:
  - `alu_op_e` enum (4-bit, values as above).
  - Opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC.
  - funct3/funct7 constants.
  - Struct `alu_issue_t` {alu_sel, op_a, op_b, rd, rd_we, illegal}.
- Sub-module `alu_decode` (combinational): instr, pc, rs1, rs2 -> `alu_issue_t`.
- `alu_issue` holds the two `alu_issue_t` registers and the handshake logic only.

## Test plan
- Reset, then `out_ready` = 1, one beat:
  - Input: `add x3,x1,x2` (0x002081B3), rs1 = 5, rs2 = 7.
  - Next cycle: out_valid = 1, sel = 0, A = 5, B = 7, rd = 3, rd_we = 1.
- `srai x5,x6,4` (0x40435293), rs1 = 0x80000000 -> sel = 7, B = 4. Then `sll`, rs2 = 0xFFFFFF21 -> B = 1.
- `auipc x1,0x12345` (0x12345097), pc = 0x100 -> sel = 11, A = 0x100, B = 0x12345. `lui` -> A = 0, sel = 10.
- Opcode 0x00000003 (load) and `add` with funct7 `0000001`:
  - illegal = 1, rd_we = 0, sel = 0, A = B = 0.
  - Both beats issue without a stall.
- Backpressure:
  - Stream beats 1..4 with `out_ready` = 0 from cycle 2: in_ready drops after the second beat is accepted.
  - Release out_ready: beats exit in order 1..4, none lost or duplicated; in_ready recovers.
- `flush` asserted with both entries full and in_valid = 1:
  - Next cycle: out_valid = 0, in_ready = 1.
  - The flushed beats never appear on the outputs.
